// File: rtl/max51_pkg.sv
// Shared widths, result layout and reset value for the max51 leaf.
// Optional min(A,B) outputs are enabled by defining MAX51_MIN_EN.
package max51_pkg;

  localparam int unsigned OPW      = 4;
  localparam int unsigned RESW     = 5;
  localparam int unsigned FLAG_BIT = 4;
  localparam int unsigned MAX_MSB  = 3;

  localparam logic [RESW-1:0] RES_RST = 5'b0;

  // Registered result word: select flag above the 4-bit maximum.
  typedef struct packed {
    logic           flag;
    logic [OPW-1:0] max;
  } result_t;

endpackage : max51_pkg

// File: rtl/max51_cmp4.sv
// Combinational 4-bit unsigned comparator, MSB-first ripple: gt = (b > a).
module max51_cmp4
  import max51_pkg::*;
(
  input  logic [OPW-1:0] a_i,
  input  logic [OPW-1:0] b_i,
  output logic           gt_c_o
);

  logic found_c;

  // First differing bit from the MSB decides; equal operands give gt=0.
  always_comb begin
    gt_c_o  = 1'b0;
    found_c = 1'b0;
    for (int i = int'(OPW) - 1; i >= 0; i--) begin
      if (!found_c && (a_i[i] != b_i[i])) begin
        gt_c_o  = b_i[i];
        found_c = 1'b1;
      end
    end
  end

endmodule : max51_cmp4

// File: rtl/max51_unit.sv
// Registered 4-bit unsigned max selector: A={pi7..pi4}, B={pi3..pi0}.
// po4 flags B > A, {po3..po0} = max(A,B), one cycle latency.
// Define MAX51_MIN_EN to add registered min(A,B) outputs pm3..pm0.
module max51_unit
  import max51_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  input  logic pi7,
  input  logic pi6,
  input  logic pi5,
  input  logic pi4,
  input  logic pi3,
  input  logic pi2,
  input  logic pi1,
  input  logic pi0,
  output logic out_valid,
`ifdef MAX51_MIN_EN
  output logic pm3,
  output logic pm2,
  output logic pm1,
  output logic pm0,
`endif
  output logic po4,
  output logic po3,
  output logic po2,
  output logic po1,
  output logic po0
);

  logic [OPW-1:0] a_c;
  logic [OPW-1:0] b_c;
  logic           gt_c;
  result_t        res_d;
  result_t        res_q;
  logic           valid_q;

  assign a_c = {pi7, pi6, pi5, pi4};
  assign b_c = {pi3, pi2, pi1, pi0};

  max51_cmp4 u_cmp (
    .a_i    (a_c),
    .b_i    (b_c),
    .gt_c_o (gt_c)
  );

  // Select the larger operand; ties keep A with flag clear.
  always_comb begin
    res_d      = RES_RST;
    res_d.flag = gt_c;
    res_d.max  = gt_c ? b_c : a_c;
  end

  // Result register loads only on valid input; valid flop tracks in_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q   <= RES_RST;
      valid_q <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        res_q <= res_d;
      end
    end
  end

  assign out_valid = valid_q;
  assign po4       = res_q.flag;
  assign {po3, po2, po1, po0} = res_q.max;

`ifdef MAX51_MIN_EN
  logic [OPW-1:0] min_d;
  logic [OPW-1:0] min_q;

  // Smaller operand; ties report A (identical to B anyway).
  always_comb begin
    min_d = gt_c ? a_c : b_c;
    if (!gt_c && (a_c == b_c)) begin
      min_d = a_c;
    end
  end

  // Min register shares the result stage and its load enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_q <= OPW'(0);
    end else if (in_valid) begin
      min_q <= min_d;
    end
  end

  assign {pm3, pm2, pm1, pm0} = min_q;
`endif

endmodule : max51_unit

// File: tb/tb_max51_unit.sv
// Directed + exhaustive bench for max51_unit with a scoreboard queue.
module tb_max51_unit;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] pi;
  logic       out_valid;
  logic       po4, po3, po2, po1, po0;
  logic [4:0] po;
`ifdef MAX51_MIN_EN
  logic       pm3, pm2, pm1, pm0;
  logic [3:0] pm;
  logic [3:0] min_q_model;
  logic [3:0] min_exp_q[$];
`endif

  int n_cmp;
  int n_fail;

  // Expected {out_valid, po} per driven cycle.
  logic [5:0] exp_q[$];
  logic [4:0] last_res;

  assign po = {po4, po3, po2, po1, po0};

  max51_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .pi7       (pi[7]),
    .pi6       (pi[6]),
    .pi5       (pi[5]),
    .pi4       (pi[4]),
    .pi3       (pi[3]),
    .pi2       (pi[2]),
    .pi1       (pi[1]),
    .pi0       (pi[0]),
    .out_valid (out_valid),
`ifdef MAX51_MIN_EN
    .pm3       (pm3),
    .pm2       (pm2),
    .pm1       (pm1),
    .pm0       (pm0),
`endif
    .po4       (po4),
    .po3       (po3),
    .po2       (po2),
    .po1       (po1),
    .po0       (po0)
  );

`ifdef MAX51_MIN_EN
  assign pm = {pm3, pm2, pm1, pm0};
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] ref_res(input logic [7:0] p);
    int a, b;
    a = int'(p[7:4]);
    b = int'(p[3:0]);
    if (b > a) return {1'b1, p[3:0]};
    else       return {1'b0, p[7:4]};
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Drive one cycle at negedge, push expectation, compare just after posedge.
  task automatic drive(input logic v, input logic [7:0] p, input string tag);
    logic [5:0] e;
    @(negedge clk);
    in_valid = v;
    pi       = p;
    if (v) last_res = ref_res(p);
    exp_q.push_back({v, last_res});
`ifdef MAX51_MIN_EN
    if (v) min_q_model = (int'(p[3:0]) > int'(p[7:4])) ? p[7:4] : p[3:0];
    min_exp_q.push_back(min_q_model);
`endif
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 8'd1, 8'd0);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_vld"}, {7'd0, out_valid}, {7'd0, e[5]});
      check({tag, "_po"},  {3'd0, po},        {3'd0, e[4:0]});
    end
`ifdef MAX51_MIN_EN
    if (min_exp_q.size() != 0)
      check({tag, "_pm"}, {4'd0, pm}, {4'd0, min_exp_q.pop_front()});
`endif
  endtask

  initial begin
    n_cmp    = 0;
    n_fail   = 0;
    last_res = 5'd0;
`ifdef MAX51_MIN_EN
    min_q_model = 4'd0;
`endif
    rst_n    = 1'b0;
    in_valid = 1'b0;
    pi       = 8'h00;

    // Held in reset while inputs toggle: outputs stay cleared.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      pi       = 8'(8'h5A + 8'(i * 37));
      @(posedge clk);
      #1;
      check("rst_hold_vld", {7'd0, out_valid}, 8'd0);
      check("rst_hold_po",  {3'd0, po},        8'd0);
    end

    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;

    // Directed cases.
    drive(1'b1, 8'b10010011, "a9_b3");
    check("a9_b3_const", {3'd0, po}, 8'b00001001);
    drive(1'b1, 8'b00101110, "a2_be");
    check("a2_be_const", {3'd0, po}, 8'b00011110);
    drive(1'b1, 8'b01110111, "tie7");
    check("tie7_const", {3'd0, po}, 8'b00000111);
`ifdef MAX51_MIN_EN
    drive(1'b1, 8'b11110000, "af_b0");
    check("af_b0_po", {3'd0, po}, 8'b00001111);
    check("af_b0_pm", {4'd0, pm}, 8'b00000000);
`endif

    // Valid pulses 1,0,0,1: out_valid follows, po holds through gaps.
    drive(1'b1, 8'b00011000, "pulse0");
    drive(1'b0, 8'b11110000, "gap1");
    check("gap1_hold", {3'd0, po}, 8'b00011000);
    drive(1'b0, 8'b00001111, "gap2");
    drive(1'b1, 8'b11000101, "pulse3");

    // Exhaustive back-to-back sweep.
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, 8'(i), "sweep");
    end

    // Asynchronous reset mid-stream, away from any clock edge.
    @(negedge clk);
    in_valid = 1'b1;
    pi       = 8'h3C;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_vld", {7'd0, out_valid}, 8'd0);
    check("async_rst_po",  {3'd0, po},        8'd0);
    last_res = 5'd0;
`ifdef MAX51_MIN_EN
    min_q_model = 4'd0;
`endif
    exp_q.delete();

    // Release, idle cycle, then first valid result one cycle later.
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    drive(1'b0, 8'hE1, "post_rst_idle");
    drive(1'b1, 8'h4B, "post_rst_first");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_max51_unit

// File: doc/max51_unit.md
Name: max51_unit

Overview:
- Registered 4-bit unsigned maximum selector, one leaf partition of the larger max datapath.
- 8 scalar data inputs form two 4-bit operands: A = {pi7,pi6,pi5,pi4}, B = {pi3,pi2,pi1,pi0}.
- 5 scalar outputs: po4 is the select flag; {po3,po2,po1,po0} is max(A,B).
- Result is registered once; a valid bit travels alongside the data.

Parameters:
- None. Widths are fixed: 4-bit operands, 5 result bits.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  data inputs are sampled this cycle
- pi7..pi4  input  1 each  operand A, pi7 is the MSB
- pi3..pi0  input  1 each  operand B, pi3 is the MSB
- out_valid  output  1  po4..po0 hold a fresh result
- po4  output  1  select flag: 1 when B > A, strictly
- po3..po0  output  1 each  max(A,B), po3 is the MSB

Behaviour:
- Reset: the asynchronous assert of rst_n=0 immediately drives out_valid=0 and po4..po0=0. Release is synchronous to clk.
- Combinational core:
  - gt = (B > A), unsigned.
  - max = gt ? B : A.
  - Ties select A, with flag 0.
- Latency: 1 cycle. On a clk rising edge with in_valid=1, the register loads {gt, max} and out_valid is set to 1.
- On a rising edge with in_valid=0:
  - out_valid drops to 0.
  - po4..po0 hold their last value; no X and no clearing.
- Back-to-back: in_valid may be high every cycle, giving throughput of 1 result per cycle. There is no backpressure.
- Reset mid-stream: any in-flight result is discarded. The first valid output after release comes 1 cycle after the first sampled in_valid=1.
- No internal state other than the output register and the valid flop. Every input is fully determined for all 256 input combinations.

Optional Feature:
- Macro: MAX51_MIN_EN.
- Defined:
  - Adds outputs pm3..pm0 (1 bit each), equal to min(A,B), where min = gt ? A : B.
  - On ties, min equals A.
  - Registered in the same stage as po* and reset to 0.
- Undefined:
  - The pm* ports are absent.
  - Behaviour of all other ports is identical.

Decomposition:
- Shared package max51_pkg:
  - OPW = 4 (operand width).
  - RESW = 5 (result width).
  - Result bit positions: FLAG_BIT = 4, MAX_MSB = 3.
  - Reset value RES_RST = 5'b0.
- One sub-module, max51_cmp4:
  - Purely combinational 4-bit unsigned comparator (MSB-first ripple) producing gt.
  - The top level holds the mux and the registers.

Test Plan:
- Reset: hold rst_n=0 and toggle inputs -> out_valid=0 and po=5'b00000. Assert rst_n mid-stream -> outputs go to 0 asynchronously, without waiting for clk.
- A=0x9, B=0x3 (pi=8'b10010011), in_valid=1 -> one cycle later po=5'b01001, out_valid=1.
- A=0x2, B=0xE (pi=8'b00101110) -> po=5'b11110. Tie with A=B=0x7 (pi=8'b01110111) -> po=5'b00111.
- Exhaustive sweep of pi=0..255 with in_valid held high -> each result appears exactly 1 cycle after its input. Each is checked against a reference model: po4=(B>A), max correct.
- in_valid pulses 1,0,0,1 -> out_valid follows 1 cycle later. po holds its last value during the gaps.
- With MAX51_MIN_EN defined, A=0xF, B=0x0 -> po=5'b01111, pm=4'b0000. Rebuild without the macro -> the pm ports are absent and po results are unchanged.
